// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 256x8 unified memory between instruction fetch
// and the data-memory stage, one access per cycle.
//   - BOOT: reads the reset vector at RESET_VEC_ADDR into boot_pc, then RUN.
//   - RUN : the data stage has fixed priority. A starvation counter forces a
//           fetch win after STARVE_MAX consecutive fetch denials.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   if_req/if_addr        fetch read request
//   if_gnt                fetch access performed this cycle (combinational)
//   if_rvalid/if_rdata    registered fetch read return (cycle after grant)
//   dm_req/dm_we/dm_addr/dm_wdata  data-stage access request
//   dm_gnt                data access performed this cycle (combinational)
//   dm_rvalid/dm_rdata    registered data read return (granted reads only)
//   boot_done/boot_pc     reset vector captured / its value
//   mem_addr/mem_we/mem_wdata/mem_rdata  memory port (combinational read)
module mem_port_arbiter #(
  parameter int unsigned    AW             = 8,
  parameter int unsigned    DW             = 8,
  parameter int unsigned    STARVE_MAX     = 4,
  parameter logic [AW-1:0]  RESET_VEC_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          boot_done,
  output logic [AW-1:0] boot_pc,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned SCW = 4;
  localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

  typedef enum logic {BOOT, RUN} state_e;

  state_e         state_q, state_d;
  logic [SCW-1:0] starve_q, starve_d;
  logic           boot_done_q, boot_done_d;
  logic [AW-1:0]  boot_pc_q, boot_pc_d;
  logic           if_rvalid_q, if_rvalid_d;
  logic [DW-1:0]  if_rdata_q, if_rdata_d;
  logic           dm_rvalid_q, dm_rvalid_d;
  logic [DW-1:0]  dm_rdata_q, dm_rdata_d;

  logic if_win, dm_win;

  // Arbitration: data stage wins unless fetch has been denied STARVE_MAX times.
  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if (state_q == RUN) begin
      if_win = if_req && (!dm_req || (starve_q == STARVE_LIM));
      dm_win = dm_req && !if_win;
    end
  end

  // Memory port mux follows the winner; idle cycles present the fetch address.
  always_comb begin
    if_gnt    = if_win;
    dm_gnt    = dm_win;
    mem_we    = dm_win && dm_we;
    mem_wdata = dm_wdata;
    if (state_q == BOOT) begin
      mem_addr = RESET_VEC_ADDR;
    end else if (dm_win) begin
      mem_addr = dm_addr;
    end else begin
      mem_addr = if_addr;
    end
  end

  // Next-state, starvation counter and read-return capture.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    boot_done_d = boot_done_q;
    boot_pc_d   = boot_pc_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rvalid_d = 1'b0;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      BOOT: begin
        boot_pc_d   = AW'(mem_rdata);
        boot_done_d = 1'b1;
        state_d     = RUN;
      end
      default: begin
        if (if_win || !if_req) begin
          starve_d = '0;
        end else if (if_req && dm_win) begin
          // Saturate so the counter can never pass the forcing threshold.
          starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + SCW'(1);
        end
        if (if_win) begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata;
        end
        if (dm_win && !dm_we) begin
          dm_rvalid_d = 1'b1;
          dm_rdata_d  = mem_rdata;
        end
      end
    endcase
  end

  // State register with asynchronous clear; reset reruns boot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      starve_q    <= '0;
      boot_done_q <= 1'b0;
      boot_pc_q   <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rvalid_q <= 1'b0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      boot_done_q <= boot_done_d;
      boot_pc_q   <= boot_pc_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rvalid_q <= dm_rvalid_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign boot_done = boot_done_q;
  assign boot_pc   = boot_pc_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 256x8 memory model
// (combinational read, write at rising edge).
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       if_req = 1'b0;
  logic [7:0] if_addr = 8'h00;
  logic       if_gnt, if_rvalid;
  logic [7:0] if_rdata;
  logic       dm_req = 1'b0;
  logic       dm_we = 1'b0;
  logic [7:0] dm_addr = 8'h00;
  logic [7:0] dm_wdata = 8'h00;
  logic       dm_gnt, dm_rvalid;
  logic [7:0] dm_rdata;
  logic       boot_done;
  logic [7:0] boot_pc;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] mem [256];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(8), .DW(8), .STARVE_MAX(4), .RESET_VEC_ADDR(8'h00)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .boot_done(boot_done), .boot_pc(boot_pc),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h02;
    mem[8'h02] = 8'h11;
    mem[8'h03] = 8'h22;
    mem[8'h04] = 8'h33;
    mem[8'h05] = 8'h44;
    mem[8'h10] = 8'hAA;

    // Held in reset with both requesters active.
    step();
    if_req = 1'b1; dm_req = 1'b1;
    #1;
    chk("rst_boot_done", {7'b0, boot_done}, 8'h00);
    chk("rst_boot_pc",   boot_pc,           8'h00);
    chk("rst_if_rvalid", {7'b0, if_rvalid}, 8'h00);
    chk("rst_dm_rvalid", {7'b0, dm_rvalid}, 8'h00);
    chk("rst_if_rdata",  if_rdata,          8'h00);
    chk("rst_dm_rdata",  dm_rdata,          8'h00);
    chk("rst_gnts",      {6'b0, if_gnt, dm_gnt}, 8'h00);
    chk("rst_mem_we",    {7'b0, mem_we},    8'h00);
    chk("rst_mem_addr",  mem_addr,          8'h00);

    // BOOT cycle: requests ignored, reset vector address on the bus.
    step();
    rst = 1'b0;
    dm_we = 1'b0; dm_addr = 8'h10; if_addr = 8'h03;
    #1;
    chk("boot_gnts",      {6'b0, if_gnt, dm_gnt}, 8'h00);
    chk("boot_mem_addr",  mem_addr,          8'h00);
    chk("boot_done_low",  {7'b0, boot_done}, 8'h00);

    // Continuous dual requests: dm wins 4 cycles, fetch wins the 5th.
    for (int k = 0; k < 10; k++) begin
      step();
      #1;
      if (k == 0) begin
        chk("boot_done_high", {7'b0, boot_done}, 8'h01);
        chk("boot_pc",        boot_pc,           8'h02);
      end
      chk($sformatf("starve_if_gnt%0d", k), {7'b0, if_gnt}, (k % 5 == 4) ? 8'h01 : 8'h00);
      chk($sformatf("starve_dm_gnt%0d", k), {7'b0, dm_gnt}, (k % 5 == 4) ? 8'h00 : 8'h01);
      chk($sformatf("starve_addr%0d", k), mem_addr, (k % 5 == 4) ? 8'h03 : 8'h10);
      if (k == 0) begin
        chk("first_if_rvalid", {7'b0, if_rvalid}, 8'h00);
        chk("first_dm_rvalid", {7'b0, dm_rvalid}, 8'h00);
      end else begin
        chk($sformatf("starve_if_rvalid%0d", k), {7'b0, if_rvalid},
            ((k - 1) % 5 == 4) ? 8'h01 : 8'h00);
        chk($sformatf("starve_dm_rvalid%0d", k), {7'b0, dm_rvalid},
            ((k - 1) % 5 == 4) ? 8'h00 : 8'h01);
        chk($sformatf("starve_dm_rdata%0d", k), dm_rdata, 8'hAA);
      end
      if (k == 5) chk("starve_if_rdata", if_rdata, 8'h22);
    end

    // Data write 0x55 to 0xFF.
    step();
    if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'hFF; dm_wdata = 8'h55;
    #1;
    chk("wr_dm_gnt",    {7'b0, dm_gnt}, 8'h01);
    chk("wr_mem_we",    {7'b0, mem_we}, 8'h01);
    chk("wr_mem_addr",  mem_addr,       8'hFF);
    chk("wr_mem_wdata", mem_wdata,      8'h55);
    chk("wr_if_rvalid", {7'b0, if_rvalid}, 8'h01);
    chk("wr_if_rdata",  if_rdata,       8'h22);

    // Read back 0xFF on the next cycle.
    step();
    dm_we = 1'b0;
    #1;
    chk("rb_dm_gnt",     {7'b0, dm_gnt},    8'h01);
    chk("rb_mem_we",     {7'b0, mem_we},    8'h00);
    chk("rb_no_rvalid",  {7'b0, dm_rvalid}, 8'h00);
    chk("rb_mem_rdata",  mem_rdata,         8'h55);

    // Idle: no grant, address follows fetch, read data returned.
    step();
    dm_req = 1'b0; if_addr = 8'h02;
    #1;
    chk("idle_gnts",     {6'b0, if_gnt, dm_gnt}, 8'h00);
    chk("idle_mem_addr", mem_addr,          8'h02);
    chk("idle_mem_we",   {7'b0, mem_we},    8'h00);
    chk("rb_dm_rvalid",  {7'b0, dm_rvalid}, 8'h01);
    chk("rb_dm_rdata",   dm_rdata,          8'h55);

    // Fetch alone over 0x02..0x05.
    for (int i = 0; i < 4; i++) begin
      step();
      if_req = 1'b1; if_addr = 8'(8'h02 + i);
      #1;
      chk($sformatf("fa_if_gnt%0d", i), {7'b0, if_gnt}, 8'h01);
      chk($sformatf("fa_dm_gnt%0d", i), {7'b0, dm_gnt}, 8'h00);
      if (i > 0) begin
        chk($sformatf("fa_if_rvalid%0d", i), {7'b0, if_rvalid}, 8'h01);
        chk($sformatf("fa_if_rdata%0d", i), if_rdata, 8'(8'h11 * i));
      end
    end
    step();
    if_req = 1'b0;
    #1;
    chk("fa_last_rvalid", {7'b0, if_rvalid}, 8'h01);
    chk("fa_last_rdata",  if_rdata,          8'h44);
    chk("fa_dm_rdata_hold", dm_rdata,        8'h55);
    chk("fa_dm_rvalid",   {7'b0, dm_rvalid}, 8'h00);

    // Reset in the middle of back-to-back granted fetch reads.
    step();
    if_req = 1'b1; if_addr = 8'h03;
    step();
    if_addr = 8'h04;
    #1;
    chk("mid_if_rvalid_pre", {7'b0, if_rvalid}, 8'h01);
    rst = 1'b1;
    mem[8'h00] = 8'h07;
    #1;
    chk("mid_if_rvalid", {7'b0, if_rvalid}, 8'h00);
    chk("mid_dm_rvalid", {7'b0, dm_rvalid}, 8'h00);
    chk("mid_boot_done", {7'b0, boot_done}, 8'h00);
    chk("mid_if_rdata",  if_rdata,          8'h00);
    chk("mid_gnts",      {6'b0, if_gnt, dm_gnt}, 8'h00);
    step();
    rst = 1'b0; if_req = 1'b0;
    #1;
    chk("reboot_done_low", {7'b0, boot_done}, 8'h00);
    step();
    #1;
    chk("reboot_done", {7'b0, boot_done}, 8'h01);
    chk("reboot_pc",   boot_pc,           8'h07);
    chk("wr_persist",  mem[8'hFF],        8'h55);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the processor's single 256x8 unified memory between the instruction-fetch stage and the data-memory stage, one access per cycle. The data stage has fixed priority, and a starvation counter guarantees forward progress for fetch. After reset the block reads the reset vector from memory and presents it as the initial PC before granting any pipeline access. It sits in `top` between the pipeline stages and `u_Memory`.

## Interface
- `AW`, 8, address width
- `DW`, 8, data width
- `STARVE_MAX`, 4, consecutive fetch denials before fetch is forced to win (1..15)
- `RESET_VEC_ADDR`, 8'h00, address read during boot

- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch requests a read
- `if_addr`  in  AW  fetch address
- `if_gnt`  out  1  fetch access performed this cycle (0 = fetch stalls)
- `if_rvalid`  out  1  `if_rdata` valid (cycle after grant)
- `if_rdata`  out  DW  registered fetch read data
- `dm_req`  in  1  data stage requests an access
- `dm_we`  in  1  1 = write, 0 = read
- `dm_addr`  in  AW  data address
- `dm_wdata`  in  DW  write data
- `dm_gnt`  out  1  data access performed this cycle
- `dm_rvalid`  out  1  `dm_rdata` valid (cycle after a granted read only)
- `dm_rdata`  out  DW  registered data read result
- `boot_done`  out  1  reset vector captured; pipeline may run
- `boot_pc`  out  AW  captured reset vector
- `mem_addr`  out  AW  memory address
- `mem_we`  out  1  memory write enable (write at rising edge)
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory combinational read data

## Operation
- States: BOOT, RUN. Reset forces BOOT.
- BOOT: `mem_addr`=RESET_VEC_ADDR, `mem_we`=0, both gnt=0. At the next edge, capture `mem_rdata` into `boot_pc`, set `boot_done`=1, and go to RUN. `boot_done` stays 1 until reset.
- RUN arbitration (combinational):
  - Only one requester: that requester is granted.
  - Both requesting: the data stage wins unless `starve_cnt`==STARVE_MAX, in which case fetch wins.
  - No request: no grant, `mem_we`=0, `mem_addr` holds `if_addr`.
- The memory mux follows the winner. `mem_we` = `dm_gnt & dm_we`. Fetch never writes.
- `starve_cnt` has 4 bits:
  - Increments when `if_req & dm_gnt`.
  - Clears when `if_gnt` or `!if_req`.
  - Never exceeds STARVE_MAX.
- Read return: on the edge after a granted read, the winner's rdata register loads `mem_rdata` and its rvalid pulses for 1 cycle. The other rdata register holds its value.
- Writes produce no rvalid.
- A read of an address written in the previous cycle returns the new data, because memory writes at the edge.
- `dm_req` and `if_req` are ignored in BOOT; requesters must hold their request until granted.

## Timing
- Reset values:
  - state=BOOT, `boot_done`=0, `boot_pc`=0, `starve_cnt`=0.
  - `if_rvalid`=`dm_rvalid`=0, `if_rdata`=`dm_rdata`=0.
  - gnt=0, `mem_we`=0, `mem_addr`=RESET_VEC_ADDR.
- Boot latency: `boot_done` rises 1 edge after `rst` falls. The first grant is possible in the following cycle.
- Grant latency: 0 cycles (same cycle as req). Read data latency: 1 cycle.
- Throughput: 1 access/cycle. Under continuous dual requests, fetch gets 1 grant per STARVE_MAX+1 cycles.
- Reset mid-operation:
  - Asynchronous clear of all state, including any pending rvalid.
  - An in-progress write completes only if its edge precedes `rst` assertion.
  - Boot reruns after reset.

## Test plan
- Boot: Mem[0]=0x02, release `rst` -> `boot_done`=1 after 1 edge, `boot_pc`=0x02, no gnt during BOOT even with `if_req`=`dm_req`=1.
- Priority: both request, `dm_addr`=0x10 (Mem=0xAA), `if_addr`=0x03 -> `dm_gnt`=1, `if_gnt`=0, next cycle `dm_rvalid`=1, `dm_rdata`=0xAA, `if_rvalid`=0.
- Starvation: both request continuously with STARVE_MAX=4 -> `dm_gnt` for 4 cycles, `if_gnt` on the 5th, pattern repeats; `starve_cnt` never exceeds 4.
- Write/readback: dm write 0x55 to 0xFF, next cycle dm read 0xFF -> Mem[0xFF]=0x55, `dm_rdata`=0x55 one cycle later, no rvalid on the write cycle.
- Fetch alone: `if_req`=1 for addresses 0x02..0x05, `dm_req`=0 -> `if_gnt`=1 every cycle, `if_rdata` streams Mem[0x02..0x05] with 1-cycle lag.
- Reset mid-op: assert `rst` during a granted read -> `if_rvalid`/`dm_rvalid`=0 immediately, `boot_done`=0; on release, boot recaptures Mem[0].
